// File: rtl/keypad_number_entry_if.sv
// rtl/keypad_number_entry_if.sv - key event and BCD result bundle for the number-entry buffer
//
// Purpose: groups the keyboard-side event signals and the number-entry results.
// Ports (signals):
//   load              freeze request (master -> slave)
//   key_down_onepulse single-cycle key-down qualifier (master -> slave)
//   last_change       9-bit scancode, bit 8 = E0 prefix (master -> slave)
//   bcd               packed BCD value, nibble 0 = LSD (slave -> master)
//   digit_count       number of digits held (slave -> master)
//   last_digit        most recently accepted digit (slave -> master)
//   entry_done        one-cycle commit pulse (slave -> master)
//   overflow          one-cycle full pulse (slave -> master)
//   busy              high while editing (slave -> master)
interface keypad_number_entry_if #(
  parameter int DIGITS = 4
);
  localparam int CW = $clog2(DIGITS + 1);

  logic                  load;
  logic                  key_down_onepulse;
  logic [8:0]            last_change;
  logic [4*DIGITS-1:0]   bcd;
  logic [CW-1:0]         digit_count;
  logic [3:0]            last_digit;
  logic                  entry_done;
  logic                  overflow;
  logic                  busy;

  modport master (
    output load, key_down_onepulse, last_change,
    input  bcd, digit_count, last_digit, entry_done, overflow, busy
  );

  modport slave (
    input  load, key_down_onepulse, last_change,
    output bcd, digit_count, last_digit, entry_done, overflow, busy
  );
endinterface

// File: rtl/keypad_number_entry.sv
// rtl/keypad_number_entry.sv - multi-digit BCD number-entry buffer driven by PS/2 key-down events
//
// Purpose: shifts decimal key presses into a DIGITS-wide packed BCD value, with
// Backspace (delete LSD), Escape (clear) and Enter (commit).
// Ports:
//   clk  system clock
//   rst  asynchronous active-low reset
//   kif  keypad_number_entry_if.slave: key events in, BCD value and status out
module keypad_number_entry #(
  parameter int DIGITS    = 4,
  parameter int KEYPAD_EN = 1,
  parameter int FULL_MODE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  keypad_number_entry_if.slave   kif
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    K_NONE  = 3'd0,
    K_DIGIT = 3'd1,
    K_BACK  = 3'd2,
    K_ENTER = 3'd3,
    K_ESC   = 3'd4
  } key_t;

  state_t         state_q, state_d;
  logic [W-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     last_q, last_d;
  logic           done_q, done_d;
  logic           ovf_q, ovf_d;

  key_t           kind;
  logic [3:0]     dig;
  logic [W-1:0]   dig_ext;
  logic [W-1:0]   shifted;

  // {valid, digit} for main-row digit scancodes
  function automatic logic [4:0] main_digit(input logic [8:0] c);
    case (c)
      9'h045: main_digit = {1'b1, 4'd0};
      9'h016: main_digit = {1'b1, 4'd1};
      9'h01E: main_digit = {1'b1, 4'd2};
      9'h026: main_digit = {1'b1, 4'd3};
      9'h025: main_digit = {1'b1, 4'd4};
      9'h02E: main_digit = {1'b1, 4'd5};
      9'h036: main_digit = {1'b1, 4'd6};
      9'h03D: main_digit = {1'b1, 4'd7};
      9'h03E: main_digit = {1'b1, 4'd8};
      9'h046: main_digit = {1'b1, 4'd9};
      default: main_digit = 5'd0;
    endcase
  endfunction

  // Keypad codes only match without the E0 prefix; E0 forms are navigation keys.
  function automatic logic [4:0] pad_digit(input logic [8:0] c);
    case (c)
      9'h070: pad_digit = {1'b1, 4'd0};
      9'h069: pad_digit = {1'b1, 4'd1};
      9'h072: pad_digit = {1'b1, 4'd2};
      9'h07A: pad_digit = {1'b1, 4'd3};
      9'h06B: pad_digit = {1'b1, 4'd4};
      9'h073: pad_digit = {1'b1, 4'd5};
      9'h074: pad_digit = {1'b1, 4'd6};
      9'h06C: pad_digit = {1'b1, 4'd7};
      9'h075: pad_digit = {1'b1, 4'd8};
      9'h07D: pad_digit = {1'b1, 4'd9};
      default: pad_digit = 5'd0;
    endcase
  endfunction

  always_comb begin
    logic [4:0] m;
    logic [4:0] p;
    kind = K_NONE;
    dig  = 4'd0;
    m    = main_digit(kif.last_change);
    p    = (KEYPAD_EN != 0) ? pad_digit(kif.last_change) : 5'd0;
    if (m[4]) begin
      kind = K_DIGIT;
      dig  = m[3:0];
    end else if (p[4]) begin
      kind = K_DIGIT;
      dig  = p[3:0];
    end else if (kif.last_change == 9'h066) begin
      kind = K_BACK;
    end else if (kif.last_change[7:0] == 8'h5A) begin
      kind = K_ENTER;
    end else if (kif.last_change == 9'h076) begin
      kind = K_ESC;
    end
  end

  // Shifting through a W-bit expression makes DIGITS=1 a plain nibble replacement.
  always_comb begin
    dig_ext      = '0;
    dig_ext[3:0] = dig;
    shifted      = (bcd_q << 4) | dig_ext;
  end

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    done_d  = 1'b0;
    ovf_d   = 1'b0;
    if (kif.key_down_onepulse && !kif.load) begin
      case (kind)
        K_DIGIT: begin
          last_d = dig;
          if (state_q == ENTRY) begin
            if (cnt_q == CW'(DIGITS)) begin
              ovf_d = 1'b1;
              if (FULL_MODE != 0) bcd_d = shifted;
            end else begin
              bcd_d = shifted;
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            // IDLE or DONE: a digit always starts a fresh entry
            bcd_d   = dig_ext;
            cnt_d   = CW'(1);
            state_d = ENTRY;
          end
        end
        K_BACK: begin
          if (state_q != IDLE) begin
            bcd_d   = bcd_q >> 4;
            cnt_d   = cnt_q - CW'(1);
            state_d = (cnt_q == CW'(1)) ? IDLE : ENTRY;
          end
        end
        K_ENTER: begin
          if (state_q == ENTRY) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
        K_ESC: begin
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 4'd0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign kif.bcd         = bcd_q;
  assign kif.digit_count = cnt_q;
  assign kif.last_digit  = last_q;
  assign kif.entry_done  = done_q;
  assign kif.overflow    = ovf_q;
  assign kif.busy        = (state_q == ENTRY);
endmodule

// File: tb/tb_keypad_number_entry.sv
// tb/tb_keypad_number_entry.sv - scoreboard bench for keypad_number_entry across parameter sets
module tb_keypad_number_entry;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic       kdp = 1'b0;
  logic [8:0] lc = 9'h000;

  always #5 clk = ~clk;

  // u0: 4 digits keypad drop; u1: 4 digits keypad roll; u2: 4 digits no keypad drop; u3: 1 digit roll
  localparam int P_D [4]  = '{4, 4, 4, 1};
  localparam int P_KP[4]  = '{1, 1, 0, 1};
  localparam int P_FM[4]  = '{0, 1, 0, 1};

  keypad_number_entry_if #(.DIGITS(4)) if0 ();
  keypad_number_entry_if #(.DIGITS(4)) if1 ();
  keypad_number_entry_if #(.DIGITS(4)) if2 ();
  keypad_number_entry_if #(.DIGITS(1)) if3 ();

  assign if0.load = load; assign if0.key_down_onepulse = kdp; assign if0.last_change = lc;
  assign if1.load = load; assign if1.key_down_onepulse = kdp; assign if1.last_change = lc;
  assign if2.load = load; assign if2.key_down_onepulse = kdp; assign if2.last_change = lc;
  assign if3.load = load; assign if3.key_down_onepulse = kdp; assign if3.last_change = lc;

  keypad_number_entry #(.DIGITS(4), .KEYPAD_EN(1), .FULL_MODE(0)) u0 (.clk(clk), .rst(rst), .kif(if0));
  keypad_number_entry #(.DIGITS(4), .KEYPAD_EN(1), .FULL_MODE(1)) u1 (.clk(clk), .rst(rst), .kif(if1));
  keypad_number_entry #(.DIGITS(4), .KEYPAD_EN(0), .FULL_MODE(0)) u2 (.clk(clk), .rst(rst), .kif(if2));
  keypad_number_entry #(.DIGITS(1), .KEYPAD_EN(1), .FULL_MODE(1)) u3 (.clk(clk), .rst(rst), .kif(if3));

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  cnt;
    logic [3:0]  last;
    logic        done;
    logic        ovf;
    logic        busy;
  } exp_t;
  typedef exp_t [3:0] exp4_t;

  exp4_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // reference model state; st: 0 IDLE, 1 ENTRY, 2 DONE
  logic [15:0] m_bcd [4];
  int          m_cnt [4];
  logic [3:0]  m_last[4];
  bit          m_done[4];
  bit          m_ovf [4];
  int          m_st  [4];

  logic [8:0] main_codes[10] = '{9'h045, 9'h016, 9'h01E, 9'h026, 9'h025,
                                 9'h02E, 9'h036, 9'h03D, 9'h03E, 9'h046};
  logic [8:0] pad_codes[10]  = '{9'h070, 9'h069, 9'h072, 9'h07A, 9'h06B,
                                 9'h073, 9'h074, 9'h06C, 9'h075, 9'h07D};

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_bcd[i] = '0; m_cnt[i] = 0; m_last[i] = '0;
      m_done[i] = 0; m_ovf[i] = 0; m_st[i] = 0;
    end
  endtask

  task automatic model_step(input bit ev, input logic [8:0] code);
    for (int i = 0; i < 4; i++) begin
      int dg;
      logic [31:0] mask;
      logic [31:0] sh;
      m_done[i] = 0;
      m_ovf[i]  = 0;
      if (!ev) continue;
      dg = -1;
      for (int k = 0; k < 10; k++) begin
        if (code == main_codes[k]) dg = k;
        if (P_KP[i] != 0 && code == pad_codes[k]) dg = k;
      end
      mask = (32'd1 << (4 * P_D[i])) - 32'd1;
      sh   = ((32'(m_bcd[i]) << 4) | 32'(dg)) & mask;
      if (dg >= 0) begin
        m_last[i] = 4'(dg);
        if (m_st[i] == 1) begin
          if (m_cnt[i] == P_D[i]) begin
            m_ovf[i] = 1;
            if (P_FM[i] != 0) m_bcd[i] = sh[15:0];
          end else begin
            m_bcd[i] = sh[15:0];
            m_cnt[i]++;
          end
        end else begin
          m_bcd[i] = 16'(dg);
          m_cnt[i] = 1;
          m_st[i]  = 1;
        end
      end else if (code == 9'h066) begin
        if (m_st[i] != 0) begin
          m_bcd[i] = m_bcd[i] >> 4;
          m_cnt[i]--;
          m_st[i]  = (m_cnt[i] == 0) ? 0 : 1;
        end
      end else if (code == 9'h05A || code == 9'h15A) begin
        if (m_st[i] == 1) begin
          m_st[i]   = 2;
          m_done[i] = 1;
        end
      end else if (code == 9'h076) begin
        m_bcd[i] = '0; m_cnt[i] = 0; m_st[i] = 0;
      end
    end
  endtask

  task automatic push_expected();
    exp4_t e;
    for (int i = 0; i < 4; i++) begin
      e[i].bcd  = m_bcd[i];
      e[i].cnt  = 4'(m_cnt[i]);
      e[i].last = m_last[i];
      e[i].done = m_done[i];
      e[i].ovf  = m_ovf[i];
      e[i].busy = (m_st[i] == 1);
    end
    sb.push_back(e);
  endtask

  function automatic exp_t observe(input int i);
    exp_t o;
    case (i)
      0: o = '{if0.bcd, {1'b0, if0.digit_count}, if0.last_digit, if0.entry_done, if0.overflow, if0.busy};
      1: o = '{if1.bcd, {1'b0, if1.digit_count}, if1.last_digit, if1.entry_done, if1.overflow, if1.busy};
      2: o = '{if2.bcd, {1'b0, if2.digit_count}, if2.last_digit, if2.entry_done, if2.overflow, if2.busy};
      default: o = '{{12'h000, if3.bcd}, {3'b000, if3.digit_count}, if3.last_digit,
                     if3.entry_done, if3.overflow, if3.busy};
    endcase
    return o;
  endfunction

  task automatic compare_outputs();
    exp4_t e;
    exp_t  o;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < 4; i++) begin
      o = observe(i);
      check($sformatf("u%0d.bcd", i),  32'(o.bcd),  32'(e[i].bcd));
      check($sformatf("u%0d.cnt", i),  32'(o.cnt),  32'(e[i].cnt));
      check($sformatf("u%0d.last", i), 32'(o.last), 32'(e[i].last));
      check($sformatf("u%0d.done", i), 32'(o.done), 32'(e[i].done));
      check($sformatf("u%0d.ovf", i),  32'(o.ovf),  32'(e[i].ovf));
      check($sformatf("u%0d.busy", i), 32'(o.busy), 32'(e[i].busy));
    end
  endtask

  task automatic cycle(input bit k, input logic [8:0] c, input bit ld);
    @(negedge clk);
    kdp = k; lc = c; load = ld;
    model_step(k && !ld, c);
    push_expected();
    @(posedge clk);
    #1;
    compare_outputs();
    kdp = 1'b0;
    load = 1'b0;
  endtask

  task automatic press(input logic [8:0] c);
    cycle(1'b1, c, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 4; i++) begin
      exp_t o;
      o = observe(i);
      check($sformatf("%s.u%0d", tag, i), 32'(o), 32'd0);
    end
  endtask

  logic [8:0] pool[20] = '{9'h045, 9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E, 9'h036, 9'h03D,
                           9'h03E, 9'h046, 9'h069, 9'h07D, 9'h070, 9'h066, 9'h066, 9'h05A,
                           9'h15A, 9'h076, 9'h175, 9'h1F0};

  initial begin
    model_reset();
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    cycle(1'b0, 9'h000, 1'b0);
    press(9'h016); press(9'h01E); press(9'h026); press(9'h05A);
    check("plan123.bcd", 32'(if0.bcd), 32'h0123);
    check("plan123.done", 32'(if0.entry_done), 32'd1);
    cycle(1'b0, 9'h000, 1'b0);
    press(9'h03D);
    check("done_digit.bcd", 32'(if0.bcd), 32'h0007);
    press(9'h076);
    cycle(1'b1, 9'h02E, 1'b1);
    cycle(1'b0, 9'h000, 1'b1);
    press(9'h046); press(9'h03E); press(9'h03D); press(9'h036); press(9'h02E);
    check("drop.bcd", 32'(if0.bcd), 32'h9876);
    check("roll.bcd", 32'(if1.bcd), 32'h8765);
    press(9'h02E);
    press(9'h05A); press(9'h066);
    press(9'h076);
    press(9'h025); press(9'h02E); press(9'h066); press(9'h066); press(9'h066);
    press(9'h069); press(9'h15A);
    check("kp_off.bcd", 32'(if2.bcd), 32'h0000);
    press(9'h176); press(9'h1F0);

    // asynchronous reset between edges with an entry_done pulse in flight
    press(9'h025); press(9'h02E); press(9'h036); press(9'h05A);
    #2 rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    for (int n = 0; n < 500; n++) begin
      cycle(($urandom_range(0, 9) < 7), pool[$urandom_range(0, 19)], ($urandom_range(0, 9) == 0));
    end
    cycle(1'b0, 9'h000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/keypad_number_entry.md
Name: keypad_number_entry

Overview:
- Parametrised multi-digit BCD number-entry buffer for the PS/2 keyboard path.
- Converts key-down events on decimal keys into a DIGITS-wide packed BCD value, shifting in one digit per key press.
- Supports main-row and numeric-keypad digits, Backspace, Escape (clear) and Enter (commit).
- Sits between the keyboard decoder (last_change / one-pulse key-down) and the calculator/display datapath.

Parameters:
- DIGITS, 4, number of BCD digits held; must be ≥1.
- KEYPAD_EN, 1, 1 = numeric-keypad digit codes are accepted as digits; 0 = they are ignored.
- FULL_MODE, 0, action on a digit while full: 0 = drop the digit; 1 = roll, discarding the most-significant digit.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- load  in  1  freeze: while high, all key events are ignored and all state is held.
- key_down_onepulse  in  1  single-cycle key-down event qualifier.
- last_change  in  9  scancode; bit 8 = E0 extended prefix.
- bcd  out  4*DIGITS  packed value; nibble 0 = least-significant digit.
- digit_count  out  $clog2(DIGITS+1)  number of digits entered.
- last_digit  out  4  most recently accepted digit.
- entry_done  out  1  one-cycle pulse on commit.
- overflow  out  1  one-cycle pulse when a digit arrives while full.
- busy  out  1  high in state ENTRY.

Behaviour:
- Reset (rst low, asynchronous): bcd=0, digit_count=0, last_digit=0, entry_done=0, overflow=0, state=IDLE.
- Key events:
  - An event is accepted only in a cycle where key_down_onepulse=1 and load=0.
  - All outputs are registered; an accepted event takes effect on the next clk edge (latency 1).
  - entry_done and overflow are high for exactly that one cycle.
- Decode of last_change:
  - Main-row digits: 0–9 = 9'h045, 016, 01E, 026, 025, 02E, 036, 03D, 03E, 046.
  - Keypad digits (KEYPAD_EN=1): 0–9 = 9'h070, 069, 072, 07A, 06B, 073, 074, 06C, 075, 07D.
  - Backspace = 9'h066.
  - Enter = 9'h05A or 9'h15A.
  - Escape = 9'h076.
  - Every other code is ignored, with no state change.
- States: IDLE (empty), ENTRY (editing), DONE (committed value held).
- Digit d:
  - IDLE → ENTRY: bcd = d, count = 1.
  - ENTRY, count < DIGITS: bcd = (bcd << 4) | d, count + 1.
  - ENTRY, count == DIGITS, FULL_MODE=0: no change to bcd or count; overflow pulse.
  - ENTRY, count == DIGITS, FULL_MODE=1: shift in d, MSD lost, count stays DIGITS; overflow pulse.
  - DONE: start a new entry; bcd = d, count = 1, go to ENTRY.
  - Any accepted digit also sets last_digit = d.
- Backspace:
  - ENTRY: bcd >> 4 (zero-filled at the top), count − 1; if count reaches 0, go to IDLE.
  - DONE: same edit, then go to ENTRY (or IDLE if count reaches 0).
  - IDLE: ignored.
- Enter:
  - ENTRY: go to DONE, entry_done pulse; bcd is held stable.
  - IDLE or DONE: ignored, no pulse.
- Escape (any state): bcd = 0, count = 0, go to IDLE; last_digit is unchanged.
- load:
  - A key_down_onepulse that arrives with load=1 is lost; it is not queued.
  - Deasserting load resumes from the held state.
- Width rules:
  - digit_count saturates at DIGITS and never wraps.
  - With DIGITS=1, a shift is a plain replacement of the single nibble.
- Reset asserted mid-entry clears everything immediately; pulses already in flight are dropped.

Test Plan:
- Reset, then press main-row 1,2,3 then Enter → bcd=16'h0123, count=3, one entry_done pulse, state DONE.
- DIGITS=4, FULL_MODE=0: keys 9,8,7,6,5 → bcd=16'h9876, overflow pulses once; with FULL_MODE=1 → bcd=16'h8765, count=4.
- Keys 4,5 then Backspace twice, then a third Backspace → bcd 0x45 → 0x4 → 0x0, IDLE; the third Backspace has no effect.
- KEYPAD_EN=1: 9'h069 then 9'h15A → bcd=1, entry_done pulse; KEYPAD_EN=0: 9'h069 has no effect.
- In DONE holding 0x0123, press 7 → bcd=0x7, count=1, ENTRY; Escape → all zero, IDLE; load=1 during a 5 press → no change.
- Assert rst low mid-entry between clk edges → outputs clear without waiting for clk.
